// File: rtl/qif_sweep_scheduler_if.sv
// qif_sweep_scheduler_if: groups the host-side control/config signals and the
// sweep status/spike outputs of qif_sweep_scheduler.
//   master: drives tick_i and the input-current write port, observes status.
//   slave : the scheduler; consumes tick/B writes, drives status and spikes.
interface qif_sweep_scheduler_if #(
    parameter int unsigned N   = 4,
    parameter int unsigned IDW = $clog2(N)
) ();
    logic           tick_i;
    logic           b_we_i;
    logic [IDW-1:0] b_addr_i;
    logic [7:0]     b_data_i;
    logic           busy_o;
    logic           done_o;
    logic           spike_valid_o;
    logic [IDW-1:0] spike_id_o;
    logic           overrun_o;
    logic [7:0]     v_dbg_o;

    modport master (
        output tick_i, b_we_i, b_addr_i, b_data_i,
        input  busy_o, done_o, spike_valid_o, spike_id_o, overrun_o, v_dbg_o
    );

    modport slave (
        input  tick_i, b_we_i, b_addr_i, b_data_i,
        output busy_o, done_o, spike_valid_o, spike_id_o, overrun_o, v_dbg_o
    );
endinterface

// File: rtl/qif_sweep_scheduler.sv
// qif_sweep_scheduler: time-multiplexes one quadratic integrate-and-fire update
// datapath over N virtual neurons. Each tick triggers a sweep of all neurons in
// index order (READ, CALC, WRITE per neuron), writing back V and emitting a
// spike event for each neuron that fires.
// Ports:
//   clk, rst_n          clock and synchronous active-low reset
//   bus (slave)         tick_i, b_we_i/b_addr_i/b_data_i input-current writes;
//                       busy_o, done_o, spike_valid_o/spike_id_o, overrun_o,
//                       v_dbg_o (V being written back, 0 otherwise)
module qif_sweep_scheduler #(
    parameter int unsigned       N      = 4,
    parameter int unsigned       IDW    = $clog2(N),
    parameter logic signed [7:0] VRESET = -8'sd20,
    parameter logic signed [7:0] VPEAK  = 8'sd50,
    parameter int unsigned       SHIFT  = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    qif_sweep_scheduler_if.slave bus
);

    typedef enum logic [2:0] {StIdle, StRead, StCalc, StWrite, StDone} state_e;

    state_e state_q, state_d;
    logic [IDW-1:0] idx_q, idx_d;
    logic pending_q, pending_d;
    logic overrun_q, overrun_d;

    logic signed [7:0] v_mem_q [N];
    logic signed [7:0] b_mem_q [N];
    logic signed [7:0] vop_q, bop_q;
    logic signed [7:0] result_q;

    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           spike_valid_q, spike_valid_d;
    logic [IDW-1:0] spike_id_q, spike_id_d;
    logic [7:0]     v_dbg_q, v_dbg_d;

    // QIF datapath on the operand registers.
    logic signed [15:0] vop_ext;
    logic        [15:0] sq;
    logic        [15:0] sq_sh;
    logic signed [17:0] sum;
    logic signed [7:0]  calc_result;
    logic               calc_fire;

    assign vop_ext = {{8{vop_q[7]}}, vop_q};
    // |V| <= 128 so V*V <= 16384 fits the 16-bit product without overflow.
    assign sq      = unsigned'(vop_ext * vop_ext);
    assign sq_sh   = sq >> SHIFT;
    assign sum     = {{10{vop_q[7]}}, vop_q} + {2'b00, sq_sh} + {{10{bop_q[7]}}, bop_q};

    always_comb begin
        calc_fire   = 1'b0;
        calc_result = VRESET;
        if (vop_q >= VPEAK) begin
            calc_fire   = 1'b1;
            calc_result = VRESET;
        end else if (sum > 18'sd127) begin
            calc_result = 8'sd127;
        end else if (sum < -18'sd128) begin
            calc_result = -8'sd128;
        end else begin
            calc_result = sum[7:0];
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pending_d = pending_q;
        overrun_d = overrun_q;

        // Ticks arriving mid-sweep are queued once; a second one is lost.
        if (bus.tick_i && (state_q != StIdle)) begin
            if (!pending_q) begin
                pending_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (bus.tick_i || pending_q) begin
                    state_d   = StRead;
                    idx_d     = '0;
                    pending_d = 1'b0;
                end
            end
            StRead:  state_d = StCalc;
            StCalc:  state_d = StWrite;
            StWrite: begin
                if (idx_q == IDW'(N - 1)) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = StRead;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Outputs are registered, so they are computed from the upcoming state.
        busy_d        = (state_d != StIdle);
        done_d        = (state_d == StDone);
        spike_valid_d = (state_q == StCalc) && calc_fire;
        spike_id_d    = ((state_q == StCalc) && calc_fire) ? idx_q : '0;
        v_dbg_d       = (state_q == StCalc) ? calc_result : 8'd0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            idx_q         <= '0;
            pending_q     <= 1'b0;
            overrun_q     <= 1'b0;
            vop_q         <= '0;
            bop_q         <= '0;
            result_q      <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            spike_valid_q <= 1'b0;
            spike_id_q    <= '0;
            v_dbg_q       <= '0;
            for (int i = 0; i < int'(N); i++) begin
                v_mem_q[i] <= VRESET;
                b_mem_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            pending_q     <= pending_d;
            overrun_q     <= overrun_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            spike_valid_q <= spike_valid_d;
            spike_id_q    <= spike_id_d;
            v_dbg_q       <= v_dbg_d;

            // A same-edge B write is not visible to this read: old value is taken.
            if (state_q == StRead) begin
                vop_q <= v_mem_q[idx_q];
                bop_q <= b_mem_q[idx_q];
            end
            if (state_q == StCalc) begin
                result_q <= calc_result;
            end
            if (state_q == StWrite) begin
                v_mem_q[idx_q] <= result_q;
            end
            if (bus.b_we_i && (32'(bus.b_addr_i) < N)) begin
                b_mem_q[bus.b_addr_i] <= bus.b_data_i;
            end
        end
    end

    assign bus.busy_o        = busy_q;
    assign bus.done_o        = done_q;
    assign bus.spike_valid_o = spike_valid_q;
    assign bus.spike_id_o    = spike_id_q;
    assign bus.overrun_o     = overrun_q;
    assign bus.v_dbg_o       = v_dbg_q;

endmodule
